// File: rtl/and_32x1_gate_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// and_32x1_gate_pkg : shared widths and tree-geometry helpers for the AND reduction
// Revision: 1.0
// ----------------------------------------------------------------------------
package and_32x1_gate_pkg;

   localparam int ALU_OPERAND_W = 16;
   localparam int AND_RED_W     = 2 * ALU_OPERAND_W;

   typedef logic [ALU_OPERAND_W-1:0] alu_operand_t;
   typedef logic [AND_RED_W-1:0]     and_red_vec_t;

   // Number of nodes present at a given tree level (level 0 is the raw input vector).
   function automatic int tree_width(input int n, input int level);
      int w;
      w = n;
      for (int k = 0; k < level; k++) begin
         w = (w + 1) / 2;
      end
      return w;
   endfunction

   // Bit offset of a level inside the flattened node vector.
   function automatic int tree_offset(input int n, input int level);
      int off;
      off = 0;
      for (int k = 0; k < level; k++) begin
         off = off + tree_width(n, k);
      end
      return off;
   endfunction

endpackage
`default_nettype wire

// File: rtl/and_32x1_gate_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// and_32x1_gate_if : operand and result bundle of the AND reduction gate
// Revision: 1.0
// ----------------------------------------------------------------------------
interface and_32x1_gate_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             y;
   logic             y_q;

   modport master (
      output a,
      output b,
      input  y,
      input  y_q
   );

   modport slave (
      input  a,
      input  b,
      output y,
      output y_q
   );
endinterface
`default_nettype wire

// File: rtl/and_32x1_gate_and_tree_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// and_tree_stage : one pairwise AND level, N inputs to ceil(N/2) outputs
// Revision: 1.0
// ----------------------------------------------------------------------------
module and_tree_stage #(
   parameter int N = 2
) (
   input  logic [N-1:0]         din,
   output logic [(N+1)/2-1:0]   dout
);

   genvar i;
   for (i = 0; i < N / 2; i++) begin : g_pair
      assign dout[i] = din[2*i] & din[2*i+1];
   end

   // An unpaired top element is forwarded untouched to the next level.
   if (N % 2 == 1) begin : g_odd
      assign dout[(N+1)/2-1] = din[N-1];
   end

endmodule
`default_nettype wire

// File: rtl/and_32x1_gate.sv
`default_nettype none
// ----------------------------------------------------------------------------
// and_32x1_gate : AND reduction of {a,b} with combinational and registered outputs
// Revision: 1.0
// ----------------------------------------------------------------------------
module and_32x1_gate
   import and_32x1_gate_pkg::*;
#(
   parameter int WIDTH = ALU_OPERAND_W
) (
   input  logic             clk,
   input  logic             rst,
   and_32x1_gate_if.slave   bus
);

   localparam int TOTAL  = 2 * WIDTH;
   localparam int LEVELS = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int NODES  = tree_offset(TOTAL, LEVELS + 1);

   // All tree levels live back to back in one vector; the root is the last bit.
   wire [NODES-1:0] node;

   assign node[TOTAL-1:0] = {bus.a, bus.b};

   genvar l;
   for (l = 0; l < LEVELS; l++) begin : g_level
      localparam int IN_W   = tree_width(TOTAL, l);
      localparam int OUT_W  = tree_width(TOTAL, l + 1);
      localparam int IN_OFF = tree_offset(TOTAL, l);
      localparam int OUT_OFF = tree_offset(TOTAL, l + 1);

      and_tree_stage #(
         .N (IN_W)
      ) u_stage (
         .din  (node[IN_OFF +: IN_W]),
         .dout (node[OUT_OFF +: OUT_W])
      );
   end

   assign bus.y = node[NODES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.y_q <= 1'b0;
      end else begin
         bus.y_q <= bus.y;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_and_32x1_gate.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_and_32x1_gate : randomized and directed check of the AND reduction gate
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_and_32x1_gate;
   import and_32x1_gate_pkg::*;

   localparam int W = ALU_OPERAND_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   and_32x1_gate_if #(.WIDTH(W)) bus ();

   and_32x1_gate #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: the result is 1 exactly when every one of the 2*W bits is set.
   function automatic logic ref_and(input logic [W-1:0] a, input logic [W-1:0] b);
      return ($countones({a, b}) == 2 * W) ? 1'b1 : 1'b0;
   endfunction

   task automatic check(input string tag, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic apply(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      logic e;
      @(negedge clk);
      bus.a = a;
      bus.b = b;
      #1;
      e = ref_and(a, b);
      check({tag, "_y"}, bus.y, e);
      @(posedge clk);
      #1;
      check({tag, "_yq"}, bus.y_q, e);
   endtask

   initial begin
      logic [2*W-1:0] v;
      int pos;

      bus.a = '0;
      bus.b = '0;
      rst   = 1'b1;
      #12;
      check("reset_yq", bus.y_q, 1'b0);
      check("reset_y", bus.y, 1'b0);

      // Output must stay cleared across edges while reset is held, even with y=1.
      @(negedge clk);
      bus.a = '1;
      bus.b = '1;
      @(posedge clk);
      #1;
      check("rst_hold_y", bus.y, 1'b1);
      check("rst_hold_yq", bus.y_q, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      apply("all_ones", 16'hFFFF, 16'hFFFF);
      apply("all_zero", 16'h0000, 16'h0000);
      apply("pat_0a0a", 16'b0000101000001010, 16'b0000101000001010);
      apply("pat_mix", 16'b0111001001110010, 16'b0101101101011011);
      apply("pat_b3b", 16'hFFFF, 16'b0011101100111011);

      for (int i = 0; i < 2 * W; i++) begin
         v = '1;
         v[i] = 1'b0;
         apply($sformatf("clr%0d", i), v[2*W-1:W], v[W-1:0]);
      end
      apply("restore", 16'hFFFF, 16'hFFFF);

      // Reset asserted between edges clears y_q at once and leaves y alone.
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_yq", bus.y_q, 1'b0);
      check("mid_rst_y", bus.y, 1'b1);
      @(posedge clk);
      #1;
      check("mid_rst_edge_yq", bus.y_q, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_noedge_yq", bus.y_q, 1'b0);
      @(posedge clk);
      #1;
      check("post_rst_yq", bus.y_q, 1'b1);

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(1, 0) == 1) begin
            v = '1;
            pos = int'($urandom_range(2 * W, 0));
            if (pos < 2 * W) v[pos] = 1'b0;
         end else begin
            v = {$urandom(), $urandom()};
         end
         apply($sformatf("rnd%0d", n), v[2*W-1:W], v[W-1:0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/and_32x1_gate.md
Name: and_32x1_gate

Overview:
- 32-input to 1-output AND reduction gate for the Kolache ALU.
- Two 16-bit operands are concatenated into a 32-bit vector and reduced to a single bit that is 1 only when all 32 bits are 1.
- Provides a zero-latency combinational result and a registered copy for clocked ALU paths.

Parameters:
- WIDTH, 16, bit width of each operand; total reduction width is 2*WIDTH (32 at default).

Ports:
- clk  input  1  system clock; the registered output updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears the registered output.
- a  input  WIDTH  operand A, upper half of the reduced vector.
- b  input  WIDTH  operand B, lower half of the reduced vector.
- y  output  1  combinational AND reduction of {a,b}.
- y_q  output  1  registered y.

Behaviour:
- y = &{a,b}: 1 if and only if every bit of a and every bit of b is 1; otherwise 0.
- y is purely combinational:
  - zero latency;
  - settles within the same timestep as any input change;
  - independent of clk and rst.
- y_q:
  - rst high forces y_q = 0 immediately, without waiting for a clock edge;
  - while rst is held, y_q stays 0;
  - after rst deasserts, y_q loads y on each rising clk edge (1-cycle latency).
- rst asserted mid-operation clears y_q at once and never affects y.
- Reset value: y_q = 0. y has no reset value; it always reflects the inputs.
- X/Z on any input bit:
  - any input bit at 0 forces y to 0, regardless of X on other bits;
  - otherwise y is X (standard Verilog & semantics).
- Implementation structure:
  - balanced binary tree of 2-input AND stages, log2(2*WIDTH) levels (5 at default);
  - WIDTH must be ≥ 1; 2*WIDTH need not be a power of two, and an odd element at any tree level passes through to the next level unchanged.
- No handshake, no state machine, no storage other than y_q.

Decomposition:
- Shared package holds:
  - ALU_OPERAND_W = 16;
  - AND_RED_W = 2*ALU_OPERAND_W.
- One sub-module, and_tree_stage:
  - parameterised N-input to ceil(N/2)-output pairwise AND level;
  - instantiated per level through a generate loop.
- The top level holds the concatenation, the stage chain and the y_q register.

Test Plan:
- a=16'hFFFF, b=16'hFFFF -> y=1; after one clk edge with rst=0, y_q=1.
- a=16'h0000, b=16'h0000 -> y=0, y_q=0.
- a=16'b0000101000001010, b=16'b0000101000001010 -> y=0.
- a=16'b0111001001110010, b=16'b0101101101011011 -> y=0.
- a=16'hFFFF, b=16'b0011101100111011 -> y=0.
- Single-bit-clear sweep, then reset mid-operation:
  - with all other bits 1, clear each of the 32 bits in turn -> y=0 each time; restoring all bits to 1 -> y=1;
  - with y_q=1, assert rst between clk edges -> y_q=0 immediately while y stays 1;
  - deassert rst -> y_q=1 at the next rising edge.
